vx_hw_itr_ctrl: RTL and testbench
=================================

// Module: vx_hw_itr_ctrl
// PURPOSE
//  Per-core hardware interrupt controller; slave end of VX_sfu_csr_if (hw_itr_ctrl_if) driven by the scalar CSR unit.
//  Holds per-warp enable/pending/cause state for CSR addresses in [`VX_HW_ITR_CTRL_BEGIN, `VX_HW_ITR_CTRL_END).
//  Latches external IRQ edges, arbitrates across warps and delivers one interrupt at a time to the warp scheduler over a valid/ready port.
// PARAMETERS
//  WARP_CNT   `NUM_WARPS  warps per core; WB = `LOG2UP(WARP_CNT)
//  NUM_LANES  4           lanes of read_data/write_data/tmask on the CSR interface
//  NUM_SRC    8           external IRQ sources (1..31); SB = `LOG2UP(NUM_SRC+1)
// PORTS
//  clk          in   1                 core clock
//  reset_n      in   1                 asynchronous, active-low reset
//  csr_if       slave VX_sfu_csr_if    read_enable/wid/tmask/addr -> read_data[NUM_LANES][32]; write_enable/wid/tmask/addr/data
//  irq_in       in   NUM_SRC           external requests, synchronous to clk, level-high
//  itr_valid    out  1                 interrupt offered to scheduler
//  itr_wid      out  WB                target warp
//  itr_cause    out  SB                source index
//  itr_ready    in   1                 scheduler accepts
// BEHAVIOUR
//  Clock/reset: one clock domain; reset_n asynchronous, active-low; all state clears immediately on assertion.
//  Reset values: itr_valid=0, itr_wid=0, itr_cause=0, IE/IP/CAUSE/in_service/GCTRL=0, rr pointer=0, FSM=IDLE.
//  Register map per warp, offset from `VX_HW_ITR_CTRL_BEGIN:
//   0x0 IE (RW) | 0x1 IP (R, W1C) | 0x2 CAUSE (RO) | 0x3 EOI (WO, reads 0) | 0x4 GCTRL (RW, bit0=global enable, shared by all warps).
//   Undefined offsets read 0; writes to them are ignored.
//  Reads: read_data is combinational in the same cycle, from the state of read_wid, and is broadcast to all NUM_LANES lanes. Unused bits are 0.
//  Writes: data is taken from the lowest set lane of write_tmask; write_tmask==0 means no write. Result is visible on the next cycle.
//  IRQ capture: irq_q <= irq_in. A rising edge (irq_in & ~irq_q) at cycle t sets IP[w][s] at t+1 for every w with IE[w][s]=1.
//  Same-cycle conflicts on IP: set wins over W1C.
//  Eligible warp w: GCTRL[0] & ~in_service[w] & |(IP[w] & IE[w]).
//  FSM IDLE:
//   - Pick eligible w round-robin, starting at rr+1; pick source s = lowest set bit of IP[w]&IE[w].
//   - Register itr_valid=1, itr_wid=w, itr_cause=s; go to REQ.
//  FSM REQ:
//   - itr_valid/wid/cause are held stable until itr_ready, even if IE, IP or GCTRL change meanwhile.
//   - On itr_valid&itr_ready: IP[w][s]<=0, CAUSE[w]<=s, in_service[w]<=1, rr<=w, itr_valid<=0 -> IDLE.
//  Timing: IP set at t+1 gives earliest itr_valid at t+2; minimum spacing between two deliveries is 2 cycles.
//  EOI write to warp w: in_service[w]<=0; CAUSE unchanged. EOI to a warp not in service is a no-op.
//  If a handshake and an EOI hit the same warp in one cycle, the handshake wins (in_service stays 1).
//  A warp in service is never re-offered; its new edges still accumulate in IP.
//  An edge that arrives while IP is already 1 is merged (no counting).
// CONFIGURATION
//  HW_ITR_TIMER_EN defined:
//   - Adds source index NUM_SRC (timer); IE/IP widths become NUM_SRC+1.
//   - Adds offset 0x5 TIMECMP (RW, shared by all warps) and a free-running 32-bit counter, reset to 0, that wraps.
//   - The timer "edge" fires on the cycle the counter equals TIMECMP, when TIMECMP!=0.
//   - Writing TIMECMP clears the counter on the same cycle.
//  HW_ITR_TIMER_EN undefined:
//   - No counter; offset 0x5 reads 0 and ignores writes; source index NUM_SRC is never generated.
// TESTING
//  T1 Reset: assert reset_n=0 mid-REQ -> itr_valid=0 in the same cycle; all CSRs read 0 after release.
//  T2 Basic delivery:
//   - Stimulus: GCTRL=1, IE[w2]=0x04, irq_in[2] pulsed at t.
//   - Expect: IP[w2]=0x04 at t+1; itr_valid=1, wid=2, cause=2 at t+2.
//   - With ready held 0 for 5 cycles: outputs stay stable; after the handshake, IP[w2]=0 and CAUSE=2.
//  T3 Arbitration:
//   - Stimulus: IE=0xFF for w0..w3, irq_in=0x81 once.
//   - Expect: deliveries w0,w1,w2,w3 each with cause=0; no re-offer before EOI; after EOI to w0, cause=7 is offered to w0.
//  T4 W1C race: write IP[w1]=0x01 in the same cycle as a new edge on source 0 -> IP[w1][0]=1 afterwards.
//  T5 Lane select: write_tmask=4'b0100, write_data lane2=0x3 to IE -> IE reads 0x3 on all 4 lanes; tmask=0 -> no change.
//  T6 Timer (HW_ITR_TIMER_EN):
//   - Stimulus: TIMECMP=10, IE[w0]=1<<NUM_SRC.
//   - Expect: IP[w0] bit set 11 cycles after the write; TIMECMP=0 never fires.

Source files
------------

// File: rtl/vx_hw_itr_ctrl.sv
// vx_hw_itr_ctrl: per-core hardware interrupt controller.
// Holds per-warp IE/IP/CAUSE/in-service state behind a small CSR window,
// latches external IRQ edges and offers one interrupt at a time to the
// warp scheduler over a valid/ready port.
// Optional feature macro: HW_ITR_TIMER_EN (adds timer source NUM_SRC and
// the shared TIMECMP register at offset 0x5).
module vx_hw_itr_ctrl #(
  parameter int unsigned  WARP_CNT  = 4,
  parameter int unsigned  NUM_LANES = 4,
  parameter int unsigned  NUM_SRC   = 8,
  parameter logic [11:0]  CSR_BEGIN = 12'h7C0,
  parameter logic [11:0]  CSR_END   = 12'h7C8,
  localparam int unsigned WB        = (WARP_CNT > 1) ? $clog2(WARP_CNT) : 1,
  localparam int unsigned SB        = $clog2(NUM_SRC + 1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  // CSR read side (data is combinational)
  input  logic                     csr_read_enable_i,
  input  logic [WB-1:0]            csr_read_wid_i,
  input  logic [NUM_LANES-1:0]     csr_read_tmask_i,
  input  logic [11:0]              csr_read_addr_i,
  output logic [NUM_LANES*32-1:0]  csr_read_data_c,
  // CSR write side
  input  logic                     csr_write_enable_i,
  input  logic [WB-1:0]            csr_write_wid_i,
  input  logic [NUM_LANES-1:0]     csr_write_tmask_i,
  input  logic [11:0]              csr_write_addr_i,
  input  logic [NUM_LANES*32-1:0]  csr_write_data_i,
  // External requests and scheduler port
  input  logic [NUM_SRC-1:0]       irq_in,
  output logic                     itr_valid,
  output logic [WB-1:0]            itr_wid,
  output logic [SB-1:0]            itr_cause,
  input  logic                     itr_ready
);

`ifdef HW_ITR_TIMER_EN
  localparam int unsigned IW = NUM_SRC + 1;
`else
  localparam int unsigned IW = NUM_SRC;
`endif

  localparam logic [11:0] OFF_IE      = 12'h0;
  localparam logic [11:0] OFF_IP      = 12'h1;
  localparam logic [11:0] OFF_CAUSE   = 12'h2;
  localparam logic [11:0] OFF_EOI     = 12'h3;
  localparam logic [11:0] OFF_GCTRL   = 12'h4;
`ifdef HW_ITR_TIMER_EN
  localparam logic [11:0] OFF_TIMECMP = 12'h5;
`endif

  typedef enum logic {S_IDLE, S_REQ} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       ie_q    [WARP_CNT];
  logic [IW-1:0]       ie_d    [WARP_CNT];
  logic [IW-1:0]       ip_q    [WARP_CNT];
  logic [IW-1:0]       ip_d    [WARP_CNT];
  logic [SB-1:0]       cause_q [WARP_CNT];
  logic [SB-1:0]       cause_d [WARP_CNT];
  logic [WARP_CNT-1:0] insvc_q, insvc_d;
  logic                gctrl_q, gctrl_d;
  logic [WB-1:0]       rr_q, rr_d;
  logic [NUM_SRC-1:0]  irq_q;
  logic                valid_q, valid_d;
  logic [WB-1:0]       wid_q, wid_d;
  logic [SB-1:0]       scause_q, scause_d;
`ifdef HW_ITR_TIMER_EN
  logic [31:0]         cnt_q, cnt_d;
  logic [31:0]         timecmp_q, timecmp_d;
  logic                tmr_fire;
`endif

  logic [IW-1:0]       src_edge;
  logic                hs;
  logic                wr_hit;
  logic [11:0]         wr_off;
  logic [31:0]         wr_word;
  logic [WARP_CNT-1:0] wr_sel;
  logic [WARP_CNT-1:0] elig;
  logic [11:0]         rd_off;
  logic [31:0]         rd_word;
  logic                unused_ok;

  assign itr_valid = valid_q;
  assign itr_wid   = wid_q;
  assign itr_cause = scause_q;
  assign hs        = (state_q == S_REQ) && itr_ready;

  // Source edges; the timer contributes a one-cycle pulse on compare match
`ifdef HW_ITR_TIMER_EN
  assign tmr_fire = (cnt_q == timecmp_q) && (timecmp_q != 32'd0);
  assign src_edge = {tmr_fire, irq_in & ~irq_q};
`else
  assign src_edge = irq_in & ~irq_q;
`endif

  // Write decode: data from the lowest active lane, per-warp select
  always_comb begin
    logic found;
    wr_word = '0;
    found   = 1'b0;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      if (csr_write_tmask_i[l] && !found) begin
        wr_word = csr_write_data_i[l*32 +: 32];
        found   = 1'b1;
      end
    end
    wr_off = csr_write_addr_i - CSR_BEGIN;
    wr_hit = csr_write_enable_i && (|csr_write_tmask_i)
          && (csr_write_addr_i >= CSR_BEGIN) && (csr_write_addr_i < CSR_END)
          && (32'(csr_write_wid_i) < WARP_CNT);
    for (int unsigned w = 0; w < WARP_CNT; w++) begin
      wr_sel[w] = wr_hit && (csr_write_wid_i == WB'(w));
    end
  end

  // Eligibility per warp
  always_comb begin
    for (int unsigned w = 0; w < WARP_CNT; w++) begin
      elig[w] = gctrl_q && !insvc_q[w] && (|(ip_q[w] & ie_q[w]));
    end
  end

  // CSR state next values; within IP, edge set beats W1C and handshake clear
  always_comb begin
    gctrl_d = gctrl_q;
    insvc_d = insvc_q;
    for (int unsigned w = 0; w < WARP_CNT; w++) begin
      ie_d[w]    = ie_q[w];
      ip_d[w]    = ip_q[w];
      cause_d[w] = cause_q[w];
    end
`ifdef HW_ITR_TIMER_EN
    timecmp_d = timecmp_q;
    cnt_d     = cnt_q + 32'd1;
`endif
    if (wr_hit && (wr_off == OFF_GCTRL)) gctrl_d = wr_word[0];
`ifdef HW_ITR_TIMER_EN
    // The write cycle itself counts as zero, so the counter resumes at one
    if (wr_hit && (wr_off == OFF_TIMECMP)) begin
      timecmp_d = wr_word;
      cnt_d     = 32'd1;
    end
`endif
    for (int unsigned w = 0; w < WARP_CNT; w++) begin
      if (wr_sel[w] && (wr_off == OFF_IE))  ie_d[w] = wr_word[IW-1:0];
      if (wr_sel[w] && (wr_off == OFF_IP))  ip_d[w] = ip_q[w] & ~wr_word[IW-1:0];
      if (wr_sel[w] && (wr_off == OFF_EOI)) insvc_d[w] = 1'b0;
      if (hs && (wid_q == WB'(w))) begin
        ip_d[w]    = ip_d[w] & ~(IW'(1) << scause_q);
        cause_d[w] = scause_q;
        insvc_d[w] = 1'b1;
      end
      ip_d[w] = ip_d[w] | (src_edge & ie_q[w]);
    end
  end

  // Delivery FSM: round-robin warp pick, lowest pending source, hold until ready
  always_comb begin
    logic          pick_found;
    logic [WB-1:0] pick_w;
    logic [WB-1:0] cand;
    logic [SB-1:0] pick_s;
    logic [IW-1:0] pick_mask;
    state_d    = state_q;
    valid_d    = valid_q;
    wid_d      = wid_q;
    scause_d   = scause_q;
    rr_d       = rr_q;
    pick_found = 1'b0;
    pick_w     = '0;
    cand       = '0;
    pick_s     = '0;
    for (int unsigned i = 1; i <= WARP_CNT; i++) begin
      cand = WB'((32'(rr_q) + i) % WARP_CNT);
      if (!pick_found && elig[cand]) begin
        pick_found = 1'b1;
        pick_w     = cand;
      end
    end
    pick_mask = ip_q[pick_w] & ie_q[pick_w];
    for (int s = int'(IW) - 1; s >= 0; s--) begin
      if (pick_mask[s]) pick_s = SB'(s);
    end
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d  = S_REQ;
          valid_d  = 1'b1;
          wid_d    = pick_w;
          scause_d = pick_s;
        end
      end
      S_REQ: begin
        if (itr_ready) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          rr_d    = wid_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      gctrl_q  <= 1'b0;
      insvc_q  <= '0;
      rr_q     <= '0;
      irq_q    <= '0;
      valid_q  <= 1'b0;
      wid_q    <= '0;
      scause_q <= '0;
      for (int unsigned w = 0; w < WARP_CNT; w++) begin
        ie_q[w]    <= '0;
        ip_q[w]    <= '0;
        cause_q[w] <= '0;
      end
`ifdef HW_ITR_TIMER_EN
      cnt_q     <= '0;
      timecmp_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      gctrl_q  <= gctrl_d;
      insvc_q  <= insvc_d;
      rr_q     <= rr_d;
      irq_q    <= irq_in;
      valid_q  <= valid_d;
      wid_q    <= wid_d;
      scause_q <= scause_d;
      for (int unsigned w = 0; w < WARP_CNT; w++) begin
        ie_q[w]    <= ie_d[w];
        ip_q[w]    <= ip_d[w];
        cause_q[w] <= cause_d[w];
      end
`ifdef HW_ITR_TIMER_EN
      cnt_q     <= cnt_d;
      timecmp_q <= timecmp_d;
`endif
    end
  end

  // Combinational read mux, broadcast to every lane
  always_comb begin
    rd_word = '0;
    rd_off  = csr_read_addr_i - CSR_BEGIN;
    if ((csr_read_addr_i >= CSR_BEGIN) && (csr_read_addr_i < CSR_END)
        && (32'(csr_read_wid_i) < WARP_CNT)) begin
      case (rd_off)
        OFF_IE:      rd_word = 32'(ie_q[csr_read_wid_i]);
        OFF_IP:      rd_word = 32'(ip_q[csr_read_wid_i]);
        OFF_CAUSE:   rd_word = 32'(cause_q[csr_read_wid_i]);
        OFF_GCTRL:   rd_word = {31'd0, gctrl_q};
`ifdef HW_ITR_TIMER_EN
        OFF_TIMECMP: rd_word = timecmp_q;
`endif
        default:     rd_word = '0;
      endcase
    end
  end

  assign csr_read_data_c = {NUM_LANES{rd_word}};

  // Read qualifiers are not needed for a side-effect-free read mux
  assign unused_ok = ^{csr_read_enable_i, csr_read_tmask_i, wr_word};

endmodule

// File: tb/tb_vx_hw_itr_ctrl.sv
// Directed bench for vx_hw_itr_ctrl (default build; timer scenario runs
// only when HW_ITR_TIMER_EN is defined).
module tb_vx_hw_itr_ctrl;
  localparam int unsigned WARP_CNT  = 4;
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned NUM_SRC   = 8;
  localparam int unsigned WB        = 2;
  localparam int unsigned SB        = 4;
  localparam logic [11:0] BASE      = 12'h7C0;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    rd_en;
  logic [WB-1:0]           rd_wid;
  logic [NUM_LANES-1:0]    rd_tmask;
  logic [11:0]             rd_addr;
  logic [NUM_LANES*32-1:0] rd_data;
  logic                    wr_en;
  logic [WB-1:0]           wr_wid;
  logic [NUM_LANES-1:0]    wr_tmask;
  logic [11:0]             wr_addr;
  logic [NUM_LANES*32-1:0] wr_data;
  logic [NUM_SRC-1:0]      irq_in;
  logic                    itr_valid;
  logic [WB-1:0]           itr_wid;
  logic [SB-1:0]           itr_cause;
  logic                    itr_ready;

  int n_cmp = 0;
  int n_err = 0;

  vx_hw_itr_ctrl #(
    .WARP_CNT(WARP_CNT), .NUM_LANES(NUM_LANES), .NUM_SRC(NUM_SRC),
    .CSR_BEGIN(BASE), .CSR_END(BASE + 12'h8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .csr_read_enable_i(rd_en), .csr_read_wid_i(rd_wid), .csr_read_tmask_i(rd_tmask),
    .csr_read_addr_i(rd_addr), .csr_read_data_c(rd_data),
    .csr_write_enable_i(wr_en), .csr_write_wid_i(wr_wid), .csr_write_tmask_i(wr_tmask),
    .csr_write_addr_i(wr_addr), .csr_write_data_i(wr_data),
    .irq_in(irq_in), .itr_valid(itr_valid), .itr_wid(itr_wid),
    .itr_cause(itr_cause), .itr_ready(itr_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    irq_in = '0; itr_ready = 1'b0; wr_en = 1'b0; wr_tmask = '0; wr_data = '0;
    wr_wid = '0; wr_addr = '0; rd_en = 1'b1; rd_tmask = '1; rd_wid = '0; rd_addr = BASE;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic csr_write_lanes(input logic [WB-1:0] wid, input logic [11:0] addr,
                                 input logic [NUM_LANES-1:0] tm,
                                 input logic [NUM_LANES*32-1:0] data);
    wr_en = 1'b1; wr_wid = wid; wr_addr = addr; wr_tmask = tm; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0; wr_tmask = '0; wr_data = '0;
  endtask

  task automatic csr_write(input logic [WB-1:0] wid, input logic [11:0] off,
                           input logic [31:0] data);
    csr_write_lanes(wid, BASE + off, 4'b0001, {{((NUM_LANES-1)*32){1'b0}}, data});
  endtask

  task automatic csr_read(input logic [WB-1:0] wid, input logic [11:0] off,
                          output logic [31:0] d);
    rd_wid = wid; rd_addr = BASE + off;
    #1;
    d = rd_data[31:0];
  endtask

  // Reset while an interrupt is being offered, then all CSRs read zero
  task automatic test_reset();
    logic [31:0] d, acc;
    do_reset();
    n_cmp++;
    if ({itr_valid, itr_wid, itr_cause} !== 7'd0) begin
      n_err++; $display("FAIL reset_outputs: got %b want 0", {itr_valid, itr_wid, itr_cause});
    end
    csr_write(0, 12'h4, 32'd1);
    csr_write(1, 12'h0, 32'h02);
    irq_in = 8'h02; @(negedge clk); irq_in = '0; @(negedge clk);
    n_cmp++;
    if ({itr_valid, itr_wid, itr_cause} !== {1'b1, 2'd1, 4'd1}) begin
      n_err++; $display("FAIL t1_pre_offer: got %b want 1_01_0001", {itr_valid, itr_wid, itr_cause});
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({itr_valid, itr_wid, itr_cause} !== 7'd0) begin
      n_err++; $display("FAIL t1_async_clear: got %b want 0", {itr_valid, itr_wid, itr_cause});
    end
    @(negedge clk); reset_n = 1'b1;
    for (int w = 0; w < 4; w++) begin
      acc = '0;
      for (int o = 0; o < 8; o++) begin
        csr_read(WB'(w), 12'(o), d);
        acc = acc | d;
      end
      n_cmp++;
      if (acc !== 32'd0) begin
        n_err++; $display("FAIL t1_csr_zero w%0d: got %h want 0", w, acc);
      end
    end
    @(negedge clk);
  endtask

  // Single edge on warp 2, held offer, then handshake side effects
  task automatic test_basic();
    logic [31:0] d;
    do_reset();
    csr_write(0, 12'h4, 32'd1);
    csr_write(2, 12'h0, 32'h04);
    irq_in = 8'h04; @(negedge clk); irq_in = '0;
    csr_read(2, 12'h1, d);
    n_cmp++;
    if ({itr_valid, d} !== {1'b0, 32'h04}) begin
      n_err++; $display("FAIL t2_ip_set: valid=%b ip=%h want valid=0 ip=04", itr_valid, d);
    end
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if ({itr_valid, itr_wid, itr_cause} !== {1'b1, 2'd2, 4'd2}) begin
        n_err++; $display("FAIL t2_offer_hold[%0d]: got %b want 1_10_0010", i,
                          {itr_valid, itr_wid, itr_cause});
      end
      if (i == 1)      csr_write(2, 12'h0, 32'h0);
      else if (i == 3) csr_write(0, 12'h4, 32'h0);
      else if (i < 5)  @(negedge clk);
    end
    itr_ready = 1'b1; @(negedge clk); itr_ready = 1'b0;
    n_cmp++;
    if (itr_valid !== 1'b0) begin
      n_err++; $display("FAIL t2_valid_drop: got %b want 0", itr_valid);
    end
    csr_read(2, 12'h1, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL t2_ip_clear: got %h want 0", d);
    end
    csr_read(2, 12'h2, d);
    n_cmp++;
    if (d !== 32'h2) begin
      n_err++; $display("FAIL t2_cause: got %h want 2", d);
    end
    @(negedge clk);
  endtask

  // Round-robin over four warps; warp 3 is served first so rr points at 3
  task automatic test_arbitration();
    logic [31:0] d;
    do_reset();
    csr_write(0, 12'h4, 32'd1);
    csr_write(3, 12'h0, 32'h40);
    irq_in = 8'h40; @(negedge clk); irq_in = '0; @(negedge clk);
    n_cmp++;
    if ({itr_valid, itr_wid, itr_cause} !== {1'b1, 2'd3, 4'd6}) begin
      n_err++; $display("FAIL t3_prelude: got %b want 1_11_0110", {itr_valid, itr_wid, itr_cause});
    end
    itr_ready = 1'b1; @(negedge clk); itr_ready = 1'b0;
    csr_write(3, 12'h3, 32'h0);
    for (int w = 0; w < 4; w++) csr_write(WB'(w), 12'h0, 32'hFF);
    irq_in = 8'h81; @(negedge clk); irq_in = '0; @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({itr_valid, itr_wid, itr_cause} !== {1'b1, WB'(k), 4'd0}) begin
        n_err++; $display("FAIL t3_order[%0d]: got %b want valid=1 wid=%0d cause=0", k,
                          {itr_valid, itr_wid, itr_cause}, k);
      end
      itr_ready = 1'b1; @(negedge clk); itr_ready = 1'b0;
      n_cmp++;
      if (itr_valid !== 1'b0) begin
        n_err++; $display("FAIL t3_gap[%0d]: got valid=%b want 0", k, itr_valid);
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (itr_valid !== 1'b0) begin
      n_err++; $display("FAIL t3_no_reoffer: got valid=%b want 0", itr_valid);
    end
    csr_read(0, 12'h1, d);
    n_cmp++;
    if (d !== 32'h80) begin
      n_err++; $display("FAIL t3_ip_pending: got %h want 80", d);
    end
    csr_write(0, 12'h3, 32'h0);
    @(negedge clk);
    n_cmp++;
    if ({itr_valid, itr_wid, itr_cause} !== {1'b1, 2'd0, 4'd7}) begin
      n_err++; $display("FAIL t3_after_eoi: got %b want 1_00_0111", {itr_valid, itr_wid, itr_cause});
    end
    itr_ready = 1'b1; @(negedge clk); itr_ready = 1'b0;
    csr_read(0, 12'h2, d);
    n_cmp++;
    if (d !== 32'h7) begin
      n_err++; $display("FAIL t3_cause_w0: got %h want 7", d);
    end
    @(negedge clk);
  endtask

  // W1C colliding with a new edge on the same bit; IE gating of edges
  task automatic test_w1c_race();
    logic [31:0] d;
    do_reset();
    csr_write(1, 12'h0, 32'h01);
    irq_in = 8'h01; @(negedge clk); irq_in = '0; @(negedge clk);
    irq_in = 8'h01;
    csr_write(1, 12'h1, 32'h01);
    csr_read(1, 12'h1, d);
    n_cmp++;
    if (d !== 32'h1) begin
      n_err++; $display("FAIL t4_set_wins: got %h want 1", d);
    end
    csr_read(2, 12'h1, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL t4_ie_gate: got %h want 0", d);
    end
    csr_write(1, 12'h1, 32'h01);
    irq_in = '0;
    csr_read(1, 12'h1, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL t4_w1c: got %h want 0", d);
    end
    @(negedge clk);
  endtask

  // Write data from the lowest active lane; broadcast read; empty mask ignored
  task automatic test_lane_select();
    do_reset();
    csr_write_lanes(0, BASE, 4'b0100, {32'hAA, 32'h3, 32'h55, 32'hFF});
    rd_wid = 0; rd_addr = BASE; #1;
    n_cmp++;
    if (rd_data !== {4{32'h3}}) begin
      n_err++; $display("FAIL t5_lane2: got %h want 4x00000003", rd_data);
    end
    csr_write_lanes(0, BASE, 4'b0000, {4{32'hFF}});
    rd_wid = 0; rd_addr = BASE; #1;
    n_cmp++;
    if (rd_data !== {4{32'h3}}) begin
      n_err++; $display("FAIL t5_tmask0: got %h want 4x00000003", rd_data);
    end
    @(negedge clk);
  endtask

  // Address decode: window bounds, write-only/undefined offsets, shared GCTRL
  task automatic test_decode();
    logic [31:0] d;
    do_reset();
    csr_write(0, 12'h0, 32'hFF);
    csr_write(1, 12'h0, 32'h11);
    csr_write_lanes(0, BASE + 12'h8, 4'b0001, '0);
    csr_read(0, 12'h0, d);
    n_cmp++;
    if (d !== 32'hFF) begin
      n_err++; $display("FAIL dec_out_of_window_write: got %h want ff", d);
    end
    csr_read(1, 12'h0, d);
    n_cmp++;
    if (d !== 32'h11) begin
      n_err++; $display("FAIL dec_ie_w1: got %h want 11", d);
    end
    csr_read(0, 12'h3, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL dec_eoi_reads0: got %h want 0", d);
    end
    @(negedge clk);
    csr_read(0, 12'h6, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL dec_undef_off: got %h want 0", d);
    end
    csr_read(0, 12'hFFF, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL dec_below_base: got %h want 0", d);
    end
    csr_write(3, 12'h4, 32'h1);
    csr_read(1, 12'h4, d);
    n_cmp++;
    if (d !== 32'h1) begin
      n_err++; $display("FAIL dec_gctrl_shared: got %h want 1", d);
    end
`ifndef HW_ITR_TIMER_EN
    csr_write(0, 12'h5, 32'h1234);
    csr_read(0, 12'h5, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL dec_off5_disabled: got %h want 0", d);
    end
`endif
    @(negedge clk);
  endtask

`ifdef HW_ITR_TIMER_EN
  // Timer compare: IP bit NUM_SRC set 11 cycles after the TIMECMP write
  task automatic test_timer();
    logic [31:0] d;
    do_reset();
    csr_write(0, 12'h0, 32'h100);
    csr_write(0, 12'h5, 32'd10);
    for (int i = 0; i < 10; i++) begin
      csr_read(0, 12'h1, d);
      n_cmp++;
      if (d !== 32'h0) begin
        n_err++; $display("FAIL t6_early[%0d]: got %h want 0", i, d);
      end
      @(negedge clk);
    end
    csr_read(0, 12'h1, d);
    n_cmp++;
    if (d !== 32'h100) begin
      n_err++; $display("FAIL t6_fire: got %h want 100", d);
    end
    csr_read(0, 12'h5, d);
    n_cmp++;
    if (d !== 32'd10) begin
      n_err++; $display("FAIL t6_timecmp_rd: got %h want a", d);
    end
    csr_write(0, 12'h5, 32'd0);
    csr_write(0, 12'h1, 32'h100);
    repeat (40) @(negedge clk);
    csr_read(0, 12'h1, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_err++; $display("FAIL t6_zero_never: got %h want 0", d);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_arbitration();
    test_w1c_race();
    test_lane_select();
    test_decode();
`ifdef HW_ITR_TIMER_EN
    test_timer();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
